vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_pkg.sv | 24 ++
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_pix_div.sv | 28 ++
 rtl/vga_timing_gen.sv | 78 +++++++
 tb/tb_vga_timing_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA 640x480@60 timing constants and small helpers used by the timing
// generator and any pattern generator that needs the same frame geometry.
package vga_timing_gen_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [9:0] coord_t;

  // True when lo <= v < lo + len.
  function automatic logic in_span(coord_t v, int unsigned lo, int unsigned len);
    return (32'(v) >= lo) && (32'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the VGA generator bundled for the video pipeline.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  coord_t column_o;
  coord_t row_o;
  logic   hsync_o;
  logic   vsync_o;
  logic   video_on_o;
  logic   pix_en_o;
  logic   frame_start_o;

  modport master (
    output column_o, row_o, hsync_o, vsync_o, video_on_o, pix_en_o, frame_start_o
  );

  modport slave (
    input column_o, row_o, hsync_o, vsync_o, video_on_o, pix_en_o, frame_start_o
  );

endinterface

// File: rtl/vga_pix_div.sv
// Clock-enable divider: tick marks the last clk of each pixel period and
// pix_en is its registered copy, so pix_en rises on the edge the counters move.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic pix_en_o
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;

  assign tick_o = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= '0;
      pix_en_o <= 1'b0;
    end else begin
      div_q    <= tick_o ? '0 : div_q + 1'b1;
      pix_en_o <= tick_o;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and frame-start flags aligned to the counter values.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input logic              clk_i,
  input logic              rst_i,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic   tick;
  coord_t col_q, col_d;
  coord_t row_q, row_d;
  logic   hsync_q, vsync_q, video_on_q, frame_start_q;

  vga_pix_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_div (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .tick_o  (tick),
    .pix_en_o(vga.pix_en_o)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (tick) begin
      if (col_q == 10'(H_TOTAL - 1)) begin
        col_d = '0;
        row_d = (row_q == 10'(V_TOTAL - 1)) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // Flags are decoded from the next counter values so they land on the same
  // edge as the counters they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q         <= '0;
      row_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      hsync_q       <= ~in_span(col_d, H_ACTIVE + H_FP, H_SYNC);
      vsync_q       <= ~in_span(row_d, V_ACTIVE + V_FP, V_SYNC);
      video_on_q    <= (32'(col_d) < H_ACTIVE) && (32'(row_d) < V_ACTIVE);
      frame_start_q <= (col_d == '0) && (row_d == '0);
    end
  end

  assign vga.column_o      = col_q;
  assign vga.row_o         = row_q;
  assign vga.hsync_o       = hsync_q;
  assign vga.vsync_o       = vsync_q;
  assign vga.video_on_o    = video_on_q;
  assign vga.frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator configurations driven by one clock and a
// randomly pulsed async reset, checked each cycle against a raster model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       pe;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if vga_a ();
  vga_timing_gen_if vga_b ();
  vga_timing_gen_if vga_c ();

  vga_timing_gen dut_a (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vga_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut_b (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vga_b)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) dut_c (
    .clk_i(clk),
    .rst_i(rst),
    .vga  (vga_c)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   na = 0, nb = 0, nc = 0;
  exp_t qa[$], qb[$], qc[$];

  // Expected outputs after n clock edges since reset release.
  function automatic exp_t model(int n, int dv, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb);
    exp_t e;
    int   p, c, r;
    p = n / dv;
    c = p % (ha + hf + hs + hb);
    r = (p / (ha + hf + hs + hb)) % (va + vf + vs + vb);
    e.col = 10'(c);
    e.row = 10'(r);
    e.pe  = (n != 0) && (n % dv == 0);
    e.hs  = !(c >= ha + hf && c < ha + hf + hs);
    e.vs  = !(r >= va + vf && r < va + vf + vs);
    e.vo  = (c < ha) && (r < va);
    e.fs  = (c == 0) && (r == 0);
    return e;
  endfunction

  function automatic exp_t model_a(int n);
    return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic exp_t model_b(int n);
    return model(n, 1, 10, 2, 3, 2, 6, 1, 2, 3);
  endfunction

  function automatic exp_t model_c(int n);
    return model(n, 3, 10, 2, 3, 2, 6, 1, 2, 3);
  endfunction

  task automatic check(string nm, exp_t e, exp_t a);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s t=%0t: got col=%0d row=%0d pe=%b hs=%b vs=%b vo=%b fs=%b, expected col=%0d row=%0d pe=%b hs=%b vs=%b vo=%b fs=%b",
                 nm, $time, a.col, a.row, a.pe, a.hs, a.vs, a.vo, a.fs,
                 e.col, e.row, e.pe, e.hs, e.vs, e.vo, e.fs);
    end
  endtask

  function automatic exp_t act_a();
    return {vga_a.column_o, vga_a.row_o, vga_a.pix_en_o, vga_a.hsync_o, vga_a.vsync_o,
            vga_a.video_on_o, vga_a.frame_start_o};
  endfunction

  function automatic exp_t act_b();
    return {vga_b.column_o, vga_b.row_o, vga_b.pix_en_o, vga_b.hsync_o, vga_b.vsync_o,
            vga_b.video_on_o, vga_b.frame_start_o};
  endfunction

  function automatic exp_t act_c();
    return {vga_c.column_o, vga_c.row_o, vga_c.pix_en_o, vga_c.hsync_o, vga_c.vsync_o,
            vga_c.video_on_o, vga_c.frame_start_o};
  endfunction

  // Monitor: compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (qa.size() > 0) check("dut_a", qa.pop_front(), act_a());
    if (qb.size() > 0) check("dut_b", qb.pop_front(), act_b());
    if (qc.size() > 0) check("dut_c", qc.pop_front(), act_c());
  end

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      na++;
      nb++;
      nc++;
    end
    #1;
    qa.push_back(model_a(na));
    qb.push_back(model_b(nb));
    qc.push_back(model_c(nc));
  endtask

  task automatic release_rst();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Assert reset between edges; outputs must be at reset values right away.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    na = 0;
    nb = 0;
    nc = 0;
    #1;
    check("async_rst_a", model_a(0), act_a());
    check("async_rst_b", model_b(0), act_b());
    check("async_rst_c", model_c(0), act_c());
  endtask

  initial begin
    repeat (3) step();
    release_rst();
    repeat (3400) step();
    async_reset();
    repeat ($urandom_range(1, 4)) step();
    release_rst();
    for (int s = 0; s < 8; s++) begin
      repeat ($urandom_range(50, 4000)) step();
      async_reset();
      repeat ($urandom_range(0, 3)) step();
      release_rst();
    end
    repeat (2000) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
